if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 104 ++++++++++
 tb/tb_if_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request and
// fills the IF/ID pipeline register with stall, memory-wait and redirect handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            pc_sel_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            imem_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] pc_plus4;

    // Modulo-2^XLEN increment: the top word wraps silently to zero.
    assign pc_plus4 = pc_q + XLEN'(4);

    // Redirect beats stall, stall beats memory wait; BOOT only advances the state.
    always_comb begin
        state_d    = RUN;
        req_d      = 1'b1;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        if (pc_sel_i) begin
            pc_d       = {branch_target_i[XLEN-1:2], 2'b00};
            instr_d    = NOP;
            valid_d    = 1'b0;
            misalign_d = |branch_target_i[1:0];
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (state_q == RUN) begin
            if (imem_ready_i) begin
                pc_d     = pc_plus4;
                instr_d  = imem_rdata_i;
                if_pc_d  = pc_q;
                if_pc4_d = pc_plus4;
                valid_d  = 1'b1;
            end else begin
                instr_d = NOP;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            req_q      <= 1'b0;
            pc_q       <= RESET_PC[XLEN-1:0];
            instr_q    <= NOP;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = if_pc_q;
    assign pc_plus4_o  = if_pc4_q;
    assign valid_o     = valid_q;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns its own address as data.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        pc_sel_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        misalign_o;

    int vectors = 0;
    int miscompares = 0;

    // Observation order: {req, addr, instr, pc, pc+4, valid, misalign}
    wire [130:0] obs = {imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o, valid_o, misalign_o};

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .pc_sel_i        (pc_sel_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rdata_i    (imem_rdata_i),
        .imem_ready_i    (imem_ready_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .valid_o         (valid_o),
        .misalign_o      (misalign_o)
    );

    assign imem_rdata_i = imem_addr_o;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (obs !== {1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %h expected %h", obs, {1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (imem_req_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL boot_req: got %b expected 0", imem_req_o);
        end
        step();
        vectors++;
        if (obs !== {1'b1, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL run_entry: got %h expected %h", obs, {1'b1, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] p;
            p = 32'(i * 4);
            step();
            vectors++;
            if (obs !== {1'b1, p + 32'd4, p, p, p + 32'd4, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL seq_fetch_%0d: got %h expected %h", i, obs, {1'b1, p + 32'd4, p, p, p + 32'd4, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_mem_wait();
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (obs !== {1'b1, 32'h10, 32'h13, 32'hC, 32'h10, 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL wait_cycle_%0d: got %h expected %h", i, obs, {1'b1, 32'h10, 32'h13, 32'hC, 32'h10, 1'b0, 1'b0});
            end
        end
        imem_ready_i = 1'b1;
        step();
        vectors++;
        if (obs !== {1'b1, 32'h14, 32'h10, 32'h10, 32'h14, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wait_resume: got %h expected %h", obs, {1'b1, 32'h14, 32'h10, 32'h10, 32'h14, 1'b1, 1'b0});
        end
        repeat (4) step();
    endtask

    task automatic test_stall();
        vectors++;
        if (obs !== {1'b1, 32'h24, 32'h20, 32'h20, 32'h24, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pre_stall: got %h expected %h", obs, {1'b1, 32'h24, 32'h20, 32'h20, 32'h24, 1'b1, 1'b0});
        end
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (obs !== {1'b1, 32'h24, 32'h20, 32'h20, 32'h24, 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, obs, {1'b1, 32'h24, 32'h20, 32'h20, 32'h24, 1'b1, 1'b0});
            end
        end
        stall_i = 1'b0;
        step();
        vectors++;
        if (obs !== {1'b1, 32'h28, 32'h24, 32'h24, 32'h28, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL stall_release: got %h expected %h", obs, {1'b1, 32'h28, 32'h24, 32'h24, 32'h28, 1'b1, 1'b0});
        end
    endtask

    task automatic test_redirect_over_stall();
        pc_sel_i = 1'b1;
        branch_target_i = 32'h100;
        stall_i = 1'b1;
        step();
        pc_sel_i = 1'b0;
        stall_i = 1'b0;
        vectors++;
        if (obs !== {1'b1, 32'h100, 32'h13, 32'h24, 32'h28, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL redirect_stall: got %h expected %h", obs, {1'b1, 32'h100, 32'h13, 32'h24, 32'h28, 1'b0, 1'b0});
        end
        step();
        vectors++;
        if (obs !== {1'b1, 32'h104, 32'h100, 32'h100, 32'h104, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL redirect_fetch: got %h expected %h", obs, {1'b1, 32'h104, 32'h100, 32'h100, 32'h104, 1'b1, 1'b0});
        end
    endtask

    task automatic test_misalign();
        pc_sel_i = 1'b1;
        branch_target_i = 32'h202;
        step();
        pc_sel_i = 1'b0;
        vectors++;
        if (obs !== {1'b1, 32'h200, 32'h13, 32'h100, 32'h104, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL misalign_pulse: got %h expected %h", obs, {1'b1, 32'h200, 32'h13, 32'h100, 32'h104, 1'b0, 1'b1});
        end
        step();
        vectors++;
        if (obs !== {1'b1, 32'h204, 32'h200, 32'h200, 32'h204, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL misalign_clear: got %h expected %h", obs, {1'b1, 32'h204, 32'h200, 32'h200, 32'h204, 1'b1, 1'b0});
        end
    endtask

    task automatic test_wrap();
        pc_sel_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        step();
        pc_sel_i = 1'b0;
        vectors++;
        if (imem_addr_o !== 32'hFFFF_FFFC || misalign_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wrap_redirect: got addr %h mis %b expected fffffffc 0", imem_addr_o, misalign_o);
        end
        step();
        vectors++;
        if (obs !== {1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_fetch: got %h expected %h", obs, {1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        pc_sel_i = 1'b1;
        branch_target_i = 32'h300;
        step();
        pc_sel_i = 1'b0;
        step();
        imem_ready_i = 1'b0;
        step();
        vectors++;
        if (obs !== {1'b1, 32'h304, 32'h13, 32'h300, 32'h304, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_wait: got %h expected %h", obs, {1'b1, 32'h304, 32'h13, 32'h300, 32'h304, 1'b0, 1'b0});
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (obs !== {1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected %h", obs, {1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
        end
        imem_ready_i = 1'b1;
    endtask

    task automatic test_boot_redirect();
        @(posedge clk);
        #1 rst = 1'b0;
        pc_sel_i = 1'b1;
        branch_target_i = 32'h40;
        step();
        pc_sel_i = 1'b0;
        vectors++;
        if (obs !== {1'b1, 32'h40, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL boot_redirect: got %h expected %h", obs, {1'b1, 32'h40, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0});
        end
        step();
        vectors++;
        if (obs !== {1'b1, 32'h44, 32'h40, 32'h40, 32'h44, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL boot_redirect_fetch: got %h expected %h", obs, {1'b1, 32'h44, 32'h40, 32'h40, 32'h44, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall();
        test_redirect_over_stall();
        test_misalign();
        test_wrap();
        test_async_reset();
        test_boot_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
